// File: rtl/gcd_lcm_post.sv
// LCM post-stage: latches operands on op_load, waits for the GCD result, then runs an
// iterative restoring divide (A / gcd) and a shift-add multiply (quotient * B).
module gcd_lcm_post #(
    parameter int WIDTH   = 11,
    parameter int TIMEOUT = 4095
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 op_load,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic [WIDTH-1:0]     gcd_y,
    input  logic                 gcd_done,
    output logic                 busy,
    output logic [WIDTH-1:0]     gcd_out,
    output logic [2*WIDTH-1:0]   lcm_out,
    output logic                 lcm_valid,
    output logic                 zero_op,
    output logic                 err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DIV,
        S_MULT,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_busy;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [CW-1:0]        r_wait_cnt;
    logic [BW-1:0]        r_step;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_divisor;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;

    logic [WIDTH-1:0]     r_gcd;
    logic [2*WIDTH-1:0]   r_lcm;
    logic                 r_valid;
    logic                 r_zero;
    logic                 r_err;

    logic                 w_wait_last;
    logic                 w_step_last;
    logic                 w_zero;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH:0]       w_rem_nxt;
    logic [WIDTH-1:0]     w_quot_nxt;
    logic [2*WIDTH-1:0]   w_acc_nxt;

    assign w_wait_last = (r_wait_cnt == CW'(TIMEOUT - 1));
    assign w_step_last = (r_step == BW'(WIDTH - 1));
    assign w_zero      = (r_a == '0) || (r_b == '0);

    // Quotient bits are shifted into the dividend register as it empties, MSB first.
    assign w_shift    = {r_rem[WIDTH-1:0], r_quot[WIDTH-1]};
    assign w_ge       = r_rem[WIDTH] || (w_shift >= {1'b0, r_divisor});
    assign w_rem_nxt  = w_ge ? (w_shift - {1'b0, r_divisor}) : w_shift;
    assign w_quot_nxt = {r_quot[WIDTH-2:0], w_ge};

    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_state_nxt = r_state;
        if (op_load) begin
            w_state_nxt = S_WAIT;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (gcd_done)
                        w_state_nxt = w_zero ? S_DONE : S_DIV;
                    else if (w_wait_last)
                        w_state_nxt = S_DONE;
                end
                S_DIV:   if (w_step_last) w_state_nxt = S_MULT;
                S_MULT:  if (w_step_last) w_state_nxt = S_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_DIV) ||
                       (w_state_nxt == S_MULT);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_wait_cnt <= '0;
            r_step     <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_divisor  <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_gcd      <= '0;
            r_lcm      <= '0;
            r_valid    <= 1'b0;
            r_zero     <= 1'b0;
            r_err      <= 1'b0;
        end else if (op_load) begin
            r_a        <= a_in;
            r_b        <= b_in;
            r_wait_cnt <= '0;
            r_step     <= '0;
            r_gcd      <= '0;
            r_lcm      <= '0;
            r_valid    <= 1'b0;
            r_zero     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (gcd_done) begin
                        r_gcd <= gcd_y;
                        if (w_zero) begin
                            r_lcm   <= '0;
                            r_zero  <= 1'b1;
                            r_valid <= 1'b1;
                        end else begin
                            r_quot    <= r_a;
                            r_divisor <= gcd_y;
                            r_rem     <= '0;
                            r_step    <= '0;
                        end
                    end else if (w_wait_last) begin
                        r_err   <= 1'b1;
                        r_lcm   <= '0;
                        r_valid <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                S_DIV: begin
                    r_rem  <= w_rem_nxt;
                    r_quot <= w_quot_nxt;
                    if (w_step_last) begin
                        r_step   <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, w_quot_nxt};
                        r_mplier <= r_b;
                        r_acc    <= '0;
                    end else begin
                        r_step <= r_step + BW'(1);
                    end
                end
                S_MULT: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (w_step_last) begin
                        r_lcm   <= w_acc_nxt;
                        r_valid <= 1'b1;
                    end else begin
                        r_step <= r_step + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign gcd_out   = r_gcd;
    assign lcm_out   = r_lcm;
    assign lcm_valid = r_valid;
    assign zero_op   = r_zero;
    assign err       = r_err;

endmodule
